// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing: pixel-enable divider, h/v counters, sync decodes
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             last_pixel;
  logic             hsync_next;
  logic             vsync_next;
  logic             video_on_next;

  assign p_tick     = (div_cnt == DIV_MAX);
  assign last_pixel = (pixel_x == H_MAX) && (pixel_y == V_MAX);

  // Decodes are taken from the next counter values so they land in the same
  // register update as pixel_x/pixel_y and never lag them.
  always_comb begin
    x_next = pixel_x + 10'd1;
    y_next = pixel_y;
    if (pixel_x == H_MAX) begin
      x_next = '0;
      y_next = (pixel_y == V_MAX) ? '0 : pixel_y + 10'd1;
    end
    hsync_next    = !((x_next >= HS_START) && (x_next <= HS_END));
    vsync_next    = !((y_next >= VS_START) && (y_next <= VS_END));
    video_on_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= p_tick ? '0 : div_cnt + 1'b1;
      frame_start <= p_tick && last_pixel;
      if (p_tick) begin
        pixel_x  <= x_next;
        pixel_y  <= y_next;
        hsync    <= hsync_next;
        vsync    <= vsync_next;
        video_on <= video_on_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized self-checking bench for vga_sync_gen with an arithmetic raster model
module tb_vga_sync_gen;

  localparam int HD = 20, HF = 4, HS = 6, HB = 5;
  localparam int VD = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int DIV_A = 3;
  localparam int DIV_B = 1;
  localparam int FRAME_A = HT * VT * DIV_A;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_hsync, a_vsync, a_video_on, a_p_tick, a_frame_start;
  logic [9:0] a_pixel_x, a_pixel_y;
  logic       b_hsync, b_vsync, b_video_on, b_p_tick, b_frame_start;
  logic [9:0] b_pixel_x, b_pixel_y;

  vga_sync_gen #(
    .CLK_DIV(DIV_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .hsync(a_hsync), .vsync(a_vsync),
    .video_on(a_video_on), .p_tick(a_p_tick), .pixel_x(a_pixel_x),
    .pixel_y(a_pixel_y), .frame_start(a_frame_start)
  );

  vga_sync_gen #(
    .CLK_DIV(DIV_B), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .hsync(b_hsync), .vsync(b_vsync),
    .video_on(b_video_on), .p_tick(b_p_tick), .pixel_x(b_pixel_x),
    .pixel_y(b_pixel_y), .frame_start(b_frame_start)
  );

  int checks = 0;
  int fails  = 0;
  int n_a = 0;
  int n_b = 0;
  int cyc = 0;
  int last_fs = -1;

  task automatic check_vec(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // n = edges since reset with reset_n high; every output is a pure function of n.
  task automatic check_model(input string nm, input int n, input int div,
                             input logic hs, input logic vs, input logic vo,
                             input logic pt, input logic fs,
                             input logic [9:0] px, input logic [9:0] py);
    int k, x, y;
    k = n / div;
    x = k % HT;
    y = (k / HT) % VT;
    check_vec({nm, ".pixel_x"}, px, 10'(x));
    check_vec({nm, ".pixel_y"}, py, 10'(y));
    check_bit({nm, ".p_tick"}, pt, (n % div) == div - 1);
    check_bit({nm, ".hsync"}, hs, !(x >= HD + HF && x < HD + HF + HS));
    check_bit({nm, ".vsync"}, vs, !(y >= VD + VF && y < VD + VF + VS));
    check_bit({nm, ".video_on"}, vo, (x < HD) && (y < VD));
    check_bit({nm, ".frame_start"}, fs, (k > 0) && (n % div == 0) && (k % (HT * VT) == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      n_a++;
      n_b++;
    end else begin
      n_a = 0;
      n_b = 0;
      last_fs = -1;
    end
    cyc++;
    @(negedge clk);
    check_model("a", n_a, DIV_A, a_hsync, a_vsync, a_video_on, a_p_tick,
                a_frame_start, a_pixel_x, a_pixel_y);
    check_model("b", n_b, DIV_B, b_hsync, b_vsync, b_video_on, b_p_tick,
                b_frame_start, b_pixel_x, b_pixel_y);
    if (a_frame_start) begin
      if (last_fs >= 0) check_vec("a.frame_period", 10'((cyc - last_fs) / (HT * VT)), 10'(DIV_A));
      last_fs = cyc;
    end
  endtask

  initial begin
    int found;
    reset_n = 1'b0;
    repeat (5) tick();

    reset_n = 1'b1;
    repeat (2 * FRAME_A + $urandom_range(0, 200)) tick();

    // Short reset landing mid-line, mid-frame.
    found = 0;
    for (int i = 0; i < 2 * FRAME_A && found == 0; i++) begin
      if (a_pixel_x == 10'd17 && a_pixel_y == 10'd8) found = 1;
      else tick();
    end
    check_bit("a.reach_mid_frame", found == 1, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (200) tick();

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(50, 1500)) tick();
      reset_n = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      reset_n = 1'b1;
    end

    repeat (2 * FRAME_A + 10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
